sifive_insight_instruction_tl_d_tracker: RTL

Passive tracker for the instruction-fetch TileLink port. It sits directly upstream of the instruction D-channel echo/trace stage. It snoops A-channel request handshakes and D-channel response handshakes, and keeps a per-source outstanding table. When the last D beat of each transaction arrives, it emits one completed-transaction record: address, latency, beat count and error. It never drives `a_ready` or `d_ready` and never stalls the bus.

---
 rtl/sifive_insight_instruction_tl_d_tracker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sifive_insight_instruction_tl_d_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sifive_insight_instruction_tl_d_tracker
// Purpose  : Passive snooper for the instruction-fetch TileLink port. Tracks
//            one outstanding transaction per source ID and emits a completed-
//            transaction record (address, latency, beats, error) through a
//            2-deep first-word-fall-through FIFO. Never back-pressures the bus.
// Revision : 1.0 - initial release
// ============================================================================
module sifive_insight_instruction_tl_d_tracker #(
  parameter int SOURCE_BITS     = 2,
  parameter int ADDR_BITS       = 32,
  parameter int BEAT_BYTES_LOG2 = 3,
  parameter int LAT_BITS        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic [2:0]             a_size,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [SOURCE_BITS-1:0] rec_source,
  output logic [ADDR_BITS-1:0]   rec_address,
  output logic [LAT_BITS-1:0]    rec_latency,
  output logic [7:0]             rec_beats,
  output logic                   rec_error,
  output logic                   err_dup,
  output logic                   err_unexpected,
  output logic                   rec_overflow,
  output logic [SOURCE_BITS:0]   outstanding
);

  localparam int c_DEPTH = 1 << SOURCE_BITS;
  localparam int c_REC_W = SOURCE_BITS + ADDR_BITS + LAT_BITS + 8 + 1;
  localparam logic [LAT_BITS-1:0] c_LAT_MAX = {LAT_BITS{1'b1}};

  // Per-source outstanding table
  logic [c_DEPTH-1:0]   r_busy;
  logic [ADDR_BITS-1:0] r_addr [c_DEPTH];
  logic [LAT_BITS-1:0]  r_lat  [c_DEPTH];
  logic [7:0]           r_bexp [c_DEPTH];
  logic [7:0]           r_bcnt [c_DEPTH];
  logic [c_DEPTH-1:0]   r_err;

  // Record FIFO: registered head plus one tail slot
  logic [c_REC_W-1:0]   r_head;
  logic                 r_head_v;
  logic [c_REC_W-1:0]   r_tail;
  logic                 r_tail_v;

  logic                 r_err_dup;
  logic                 r_err_unexp;
  logic                 r_overflow;
  logic [SOURCE_BITS:0] r_outstanding;

  // Handshake decode
  logic w_a_fire;
  logic w_d_fire;
  assign w_a_fire = a_valid & a_ready;
  assign w_d_fire = d_valid & d_ready;

  // D-side lookup of the addressed entry
  logic                w_d_busy;
  logic                w_d_hit;
  logic [7:0]          w_d_cnt_nxt;
  logic                w_d_err_nxt;
  logic                w_d_last;
  logic [LAT_BITS-1:0] w_d_lat;
  assign w_d_busy    = r_busy[d_source];
  assign w_d_hit     = w_d_fire & w_d_busy;
  assign w_d_cnt_nxt = r_bcnt[d_source] + 8'd1;
  assign w_d_err_nxt = r_err[d_source] | d_denied | d_corrupt;
  assign w_d_last    = w_d_hit & (w_d_cnt_nxt == r_bexp[d_source]);
  // The last beat counts its own cycle, so the reported latency is lat+1
  assign w_d_lat     = (r_lat[d_source] == c_LAT_MAX) ? c_LAT_MAX
                                                      : r_lat[d_source] + LAT_BITS'(1);

  // A-side: a last-beat completion on the same source frees the slot first,
  // so a same-cycle reallocation is not a duplicate.
  logic       w_dup;
  logic       w_unexp;
  logic [7:0] w_a_beats;
  assign w_dup     = w_a_fire & r_busy[a_source] & ~(w_d_last & (d_source == a_source));
  assign w_unexp   = w_d_fire & ~w_d_busy;
  assign w_a_beats = (a_size <= 3'(BEAT_BYTES_LOG2)) ? 8'd1
                                                     : (8'd1 << (a_size - 3'(BEAT_BYTES_LOG2)));

  // Per-entry select and next-busy decode
  logic [c_DEPTH-1:0] w_a_sel;
  logic [c_DEPTH-1:0] w_d_sel;
  logic [c_DEPTH-1:0] w_busy_nxt;
  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_entry
    assign w_a_sel[gi]    = w_a_fire & (a_source == SOURCE_BITS'(gi));
    assign w_d_sel[gi]    = w_d_hit  & (d_source == SOURCE_BITS'(gi));
    assign w_busy_nxt[gi] = w_a_sel[gi] | (r_busy[gi] & ~(w_d_sel[gi] & w_d_last));
  end

  // Population count of the next busy vector so the output tracks the table
  logic [SOURCE_BITS:0] w_busy_cnt;
  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < c_DEPTH; i++) begin
      w_busy_cnt = w_busy_cnt + {{SOURCE_BITS{1'b0}}, w_busy_nxt[i]};
    end
  end

  // Table update: A allocation wins over D bookkeeping on the same entry
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
      r_err  <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_lat[i]  <= '0;
        r_bexp[i] <= '0;
        r_bcnt[i] <= '0;
      end
    end else begin
      r_busy <= w_busy_nxt;
      for (int i = 0; i < c_DEPTH; i++) begin
        if (w_a_sel[i]) begin
          r_addr[i] <= a_address;
          r_lat[i]  <= '0;
          r_bexp[i] <= w_a_beats;
          r_bcnt[i] <= '0;
          r_err[i]  <= 1'b0;
        end else if (r_busy[i]) begin
          if (r_lat[i] != c_LAT_MAX) begin
            r_lat[i] <= r_lat[i] + LAT_BITS'(1);
          end
          if (w_d_sel[i]) begin
            r_bcnt[i] <= w_d_cnt_nxt;
            r_err[i]  <= w_d_err_nxt;
          end
        end
      end
    end
  end

  // FIFO control
  logic               w_push;
  logic [c_REC_W-1:0] w_push_rec;
  logic               w_pop;
  logic               w_full;
  logic               w_accept;
  assign w_push     = w_d_last;
  assign w_push_rec = {d_source, r_addr[d_source], w_d_lat, r_bexp[d_source], w_d_err_nxt};
  assign w_pop      = r_head_v & rec_ready;
  assign w_full     = r_head_v & r_tail_v;
  assign w_accept   = w_push & (~w_full | w_pop);

  // Record FIFO: pop shifts tail to head; a push lands in the first free slot
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head   <= '0;
      r_head_v <= 1'b0;
      r_tail   <= '0;
      r_tail_v <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_v) begin
        r_head   <= r_tail;
        r_head_v <= 1'b1;
        r_tail_v <= w_accept;
        if (w_accept) begin
          r_tail <= w_push_rec;
        end
      end else begin
        r_head_v <= w_accept;
        if (w_accept) begin
          r_head <= w_push_rec;
        end
      end
    end else if (w_accept) begin
      if (!r_head_v) begin
        r_head   <= w_push_rec;
        r_head_v <= 1'b1;
      end else begin
        r_tail   <= w_push_rec;
        r_tail_v <= 1'b1;
      end
    end
  end

  // Error pulses, sticky overflow and outstanding count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_dup     <= 1'b0;
      r_err_unexp   <= 1'b0;
      r_overflow    <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_err_dup     <= w_dup;
      r_err_unexp   <= w_unexp;
      r_outstanding <= w_busy_cnt;
      if (w_push & w_full & ~w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign rec_valid = r_head_v;
  assign {rec_source, rec_address, rec_latency, rec_beats, rec_error} = r_head;
  assign err_dup        = r_err_dup;
  assign err_unexpected = r_err_unexp;
  assign rec_overflow   = r_overflow;
  assign outstanding    = r_outstanding;

endmodule
`default_nettype wire
